// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//  Shared definitions for the RAM port arbiter: FSM state encodings and the
//  width of the burst beat counter.
//  Optional feature macro used by the arbiter top: RAM_ARB_FIXED_PRIO_EN.
package ram_port_arbiter_pkg;

    // Arbiter FSM states: no owner, or an owner holding the burst lock.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Beat counter must hold values up to BURST_MAX (max 15).
    localparam int BEAT_W = 4;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// ram_port_arbiter_rr_pick
//  Combinational rotate-priority picker. Searches in_req starting at index
//  in_ptr upward, wrapping at NUM_REQ, and reports the first set bit.
// Ports
//  in_req      NUM_REQ  request vector
//  in_ptr      IDX_W    index where the search starts (highest priority)
//  out_found   1        at least one request is set
//  out_idx     IDX_W    index of the winner (0 when none)
//  out_onehot  NUM_REQ  one-hot winner (all zero when none)
module ram_port_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] in_req,
    input  logic [IDX_W-1:0]   in_ptr,
    output logic               out_found,
    output logic [IDX_W-1:0]   out_idx,
    output logic [NUM_REQ-1:0] out_onehot
);

    int   pos_s;
    logic hit_s;

    // Walk the requests in rotated order; the first hit wins and masks later ones.
    always_comb begin
        out_found  = 1'b0;
        out_idx    = '0;
        out_onehot = '0;
        pos_s      = 0;
        hit_s      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos_s     = int'(in_ptr) + i;
            pos_s     = (pos_s >= NUM_REQ) ? (pos_s - NUM_REQ) : pos_s;
            hit_s     = in_req[pos_s] && !out_found;
            out_idx   = hit_s ? IDX_W'(pos_s) : out_idx;
            out_found = out_found | hit_s;
        end
        out_onehot[out_idx] = out_found;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//  Shares one port of a dual-port RAM among NUM_REQ requesters using
//  round-robin arbitration with a burst lock of up to BURST_MAX beats.
//  One access per cycle; read data returns one cycle after the grant with a
//  one-hot rvalid tag. Grants are combinational (zero-bubble).
//  Optional: RAM_ARB_FIXED_PRIO_EN makes requester 0 urgent (preempts any
//  other owner in the same cycle).
// Ports
//  in_clk, in_rst            clock, async active-high reset
//  in_req/in_wr              per-requester request and write flag
//  in_addr/in_wdata          packed per-requester address / write data
//  out_gnt                   one-hot grant (access accepted this cycle)
//  out_rvalid/out_rdata      read response, one cycle after read grant
//  out_ram_addr/data/wr      RAM port drive
//  in_ram_data               RAM read data
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int BURST_MAX      = 4
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic [NUM_REQ-1:0]                  in_req,
    input  logic [NUM_REQ-1:0]                  in_wr,
    input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0]   in_addr,
    input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0]   in_wdata,
    output logic [NUM_REQ-1:0]                  out_gnt,
    output logic [NUM_REQ-1:0]                  out_rvalid,
    output logic [RAM_DATA_WIDTH-1:0]           out_rdata,
    output logic [RAM_ADDR_WIDTH-1:0]           out_ram_addr,
    output logic [RAM_DATA_WIDTH-1:0]           out_ram_data,
    output logic                                out_ram_wr,
    input  logic [RAM_DATA_WIDTH-1:0]           in_ram_data
);

    localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(BURST_MAX);

    arb_state_t          state_r, state_s;
    logic [IDX_W-1:0]    owner_r, owner_s;
    logic [IDX_W-1:0]    last_r, last_s;
    logic [BEAT_W-1:0]   beat_cnt_r, beat_cnt_s;
    logic [NUM_REQ-1:0]  rvalid_r;

    logic [IDX_W-1:0]    ptr_base_s, ptr_s;
    logic                pick_found_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic                gnt_any_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [NUM_REQ-1:0]  owner_onehot_s;
    logic                urgent_s;

    // When locked, rotation starts after the owner; when idle, after the last owner.
    assign ptr_base_s = (state_r == ST_LOCKED) ? owner_r : last_r;
    assign ptr_s      = (ptr_base_s == LAST_IDX) ? '0 : (ptr_base_s + IDX_W'(1));
    assign owner_onehot_s = NUM_REQ'(1) << owner_r;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Requester 0 preempts unless it already holds the lock.
    assign urgent_s = in_req[0] && ((state_r == ST_IDLE) || (owner_r != '0));
`else
    assign urgent_s = 1'b0;
`endif

    ram_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .in_req     (in_req),
        .in_ptr     (ptr_s),
        .out_found  (pick_found_s),
        .out_idx    (pick_idx_s),
        .out_onehot (pick_onehot_s)
    );

    // Next-state logic and grant selection; grants are suppressed while in reset.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        last_s     = last_r;
        beat_cnt_s = beat_cnt_r;
        gnt_any_s  = 1'b0;
        gnt_idx_s  = owner_r;
        gnt_s      = '0;
        if (in_rst) begin
            gnt_any_s = 1'b0;
        end else if (urgent_s) begin
            gnt_any_s  = 1'b1;
            gnt_idx_s  = '0;
            gnt_s      = NUM_REQ'(1);
            owner_s    = '0;
            beat_cnt_s = BEAT_W'(1);
            state_s    = ST_LOCKED;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        gnt_any_s  = 1'b1;
                        gnt_idx_s  = pick_idx_s;
                        gnt_s      = pick_onehot_s;
                        owner_s    = pick_idx_s;
                        beat_cnt_s = BEAT_W'(1);
                        state_s    = ST_LOCKED;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (in_req[owner_r] && (beat_cnt_r < BURST_LIM)) begin
                        gnt_any_s  = 1'b1;
                        gnt_idx_s  = owner_r;
                        gnt_s      = owner_onehot_s;
                        beat_cnt_s = beat_cnt_r + BEAT_W'(1);
                    end else begin
                        // Lock released: hand over in the same cycle if anyone waits.
                        last_s = owner_r;
                        if (pick_found_s) begin
                            gnt_any_s  = 1'b1;
                            gnt_idx_s  = pick_idx_s;
                            gnt_s      = pick_onehot_s;
                            owner_s    = pick_idx_s;
                            beat_cnt_s = BEAT_W'(1);
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // RAM port mux: granted requester's fields, all zero with no grant.
    always_comb begin
        if (gnt_any_s) begin
            out_ram_addr = in_addr[int'(gnt_idx_s)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            out_ram_data = in_wdata[int'(gnt_idx_s)*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
            out_ram_wr   = in_wr[gnt_idx_s];
        end else begin
            out_ram_addr = '0;
            out_ram_data = '0;
            out_ram_wr   = 1'b0;
        end
    end

    // State, ownership and read-response pipeline registers.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            last_r     <= LAST_IDX;
            beat_cnt_r <= '0;
            rvalid_r   <= '0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            last_r     <= last_s;
            beat_cnt_r <= beat_cnt_s;
            rvalid_r   <= gnt_s & ~in_wr;
        end
    end

    assign out_gnt    = gnt_s;
    assign out_rvalid = rvalid_r;
    assign out_rdata  = in_ram_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic [3:0]  in_req = 4'b0000;
    logic [3:0]  in_wr = 4'b0000;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic [3:0]  out_gnt;
    logic [3:0]  out_rvalid;
    logic [7:0]  out_rdata;
    logic [7:0]  out_ram_addr;
    logic [7:0]  out_ram_data;
    logic        out_ram_wr;
    logic [7:0]  in_ram_data = 8'h00;

    ram_port_arbiter #(
        .NUM_REQ(4), .RAM_ADDR_WIDTH(8), .RAM_DATA_WIDTH(8), .BURST_MAX(4)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_req(in_req), .in_wr(in_wr),
        .in_addr(in_addr), .in_wdata(in_wdata), .out_gnt(out_gnt),
        .out_rvalid(out_rvalid), .out_rdata(out_rdata), .out_ram_addr(out_ram_addr),
        .out_ram_data(out_ram_data), .out_ram_wr(out_ram_wr), .in_ram_data(in_ram_data)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } gexp_t;

    typedef struct packed {
        logic [3:0] vld;
        logic [7:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    tests = 0;
    int    failed = 0;
    int    gnt_seen = 0;
    logic [7:0] mem [256];

    function automatic logic [7:0] ram_init(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    // Behavioural RAM: synchronous read, one cycle latency.
    always @(posedge in_clk) begin
        if (out_ram_wr) mem[out_ram_addr] <= out_ram_data;
        in_ram_data <= mem[out_ram_addr];
    end

    // Monitor: pops expectations whenever the DUT presents a grant or read data.
    always @(negedge in_clk) begin
        if (!in_rst) begin
            if (out_gnt != 4'b0000) begin
                gexp_t e;
                gnt_seen++;
                tests++;
                if (gq.size() == 0) begin
                    failed++;
                    $display("FAIL gnt_unexpected: got gnt=%b addr=%h at %0t, none expected", out_gnt, out_ram_addr, $time);
                end else begin
                    e = gq.pop_front();
                    if ({out_gnt, out_ram_wr, out_ram_addr, out_ram_data} !== e) begin
                        failed++;
                        $display("FAIL gnt: got gnt=%b wr=%b addr=%h data=%h, need gnt=%b wr=%b addr=%h data=%h at %0t",
                                 out_gnt, out_ram_wr, out_ram_addr, out_ram_data, e.gnt, e.wr, e.addr, e.data, $time);
                    end
                end
            end else begin
                tests++;
                if ({out_ram_wr, out_ram_addr, out_ram_data} !== 17'h0) begin
                    failed++;
                    $display("FAIL idle_port: got wr=%b addr=%h data=%h, need all 0 at %0t",
                             out_ram_wr, out_ram_addr, out_ram_data, $time);
                end
            end
            if (out_rvalid != 4'b0000) begin
                rexp_t r;
                tests++;
                if (rq.size() == 0) begin
                    failed++;
                    $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h at %0t, none expected", out_rvalid, out_rdata, $time);
                end else begin
                    r = rq.pop_front();
                    if ({out_rvalid, out_rdata} !== r) begin
                        failed++;
                        $display("FAIL rdata: got rvalid=%b rdata=%h, need rvalid=%b rdata=%h at %0t",
                                 out_rvalid, out_rdata, r.vld, r.data, $time);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic exp_gnt(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
        gexp_t e;
        e.gnt = 4'b0001 << i; e.wr = wr; e.addr = a; e.data = d;
        gq.push_back(e);
    endtask

    task automatic exp_rd(input int i, input logic [7:0] d);
        rexp_t r;
        r.vld = 4'b0001 << i; r.data = d;
        rq.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
        tests++;
        if (got !== need) begin
            failed++;
            $display("FAIL %s: got %h, need %h at %0t", name, got, need, $time);
        end
    endtask

    task automatic set_port(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
        in_wr[i] = wr;
        in_addr[i*8 +: 8] = a;
        in_wdata[i*8 +: 8] = d;
    endtask

    // Default read setup: requester i reads address 0x40+i.
    task automatic set_reads();
        for (int i = 0; i < 4; i++) set_port(i, 1'b0, 8'h40 + 8'(i), 8'h00);
    endtask

    task automatic do_reset();
        in_req = 4'b0000;
        in_rst = 1'b1;
        #1;
        check("reset_gnt", {28'h0, out_gnt}, 32'h0);
        check("reset_rvalid", {28'h0, out_rvalid}, 32'h0);
        check("reset_ram", {23'h0, out_ram_wr, out_ram_addr}, 32'h0);
        cyc(2);
        in_rst = 1'b0;
        cyc(1);
    endtask

    // Single access by requester i, request held until granted (bounded wait).
    task automatic access(input int i, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] rd);
        logic got;
        set_port(i, wr, a, d);
        exp_gnt(i, wr, a, d);
        if (!wr) exp_rd(i, rd);
        in_req[i] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge in_clk);
            got = out_gnt[i];
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL grant_timeout: requester %0d got no grant, need one within 16 cycles", i);
        end
        @(posedge in_clk);
        #1;
        in_req[i] = 1'b0;
    endtask

    initial begin
        int base;
        for (int a = 0; a < 256; a++) mem[a] = ram_init(8'(a));

        // Reset state and single read (RAM preloaded 0xA5 at 0x10)
        do_reset();
        access(1, 1'b0, 8'h10, 8'h00, 8'hA5);
        cyc(3);

        // Write 0x3C to 0x20 then read it back
        do_reset();
        access(2, 1'b1, 8'h20, 8'h3C, 8'h00);
        access(2, 1'b0, 8'h20, 8'h00, 8'h3C);
        cyc(3);

        // All four held: 4 beats each, rotating, no idle cycles
        do_reset();
        set_reads();
        for (int g = 0; g < 20; g++) begin
            exp_gnt((g / 4) % 4, 1'b0, 8'h40 + 8'((g / 4) % 4), 8'h00);
            exp_rd((g / 4) % 4, ram_init(8'h40 + 8'((g / 4) % 4)));
        end
        base = gnt_seen;
        in_req = 4'b1111;
        cyc(20);
        in_req = 4'b0000;
        cyc(3);
        check("burst_no_bubble", 32'(gnt_seen - base), 32'd20);

        // Owner drops after 2 beats; req3 takes over with a fresh burst count
        do_reset();
        set_reads();
        exp_gnt(0, 1'b0, 8'h40, 8'h00); exp_rd(0, ram_init(8'h40));
        exp_gnt(0, 1'b0, 8'h40, 8'h00); exp_rd(0, ram_init(8'h40));
        for (int k = 0; k < 4; k++) begin
            exp_gnt(3, 1'b0, 8'h43, 8'h00); exp_rd(3, ram_init(8'h43));
        end
        exp_gnt(1, 1'b0, 8'h41, 8'h00); exp_rd(1, ram_init(8'h41));
        in_req = 4'b1001;
        cyc(2);
        in_req[0] = 1'b0;
        cyc(1);
        in_req[1] = 1'b1;
        cyc(4);
        in_req = 4'b0000;
        cyc(3);

        // Reset mid read burst: immediate clear, then req2 wins over req3
        do_reset();
        set_reads();
        exp_gnt(1, 1'b0, 8'h41, 8'h00); exp_rd(1, ram_init(8'h41));
        exp_gnt(1, 1'b0, 8'h41, 8'h00);
        in_req = 4'b0010;
        cyc(2);
        #2;
        in_rst = 1'b1;
        #1;
        check("midreset_gnt", {28'h0, out_gnt}, 32'h0);
        check("midreset_rvalid", {28'h0, out_rvalid}, 32'h0);
        in_req = 4'b1100;
        exp_gnt(2, 1'b0, 8'h42, 8'h00); exp_rd(2, ram_init(8'h42));
        cyc(2);
        in_rst = 1'b0;
        cyc(1);
        in_req = 4'b0000;
        cyc(3);

        // req0 arrives while req1 is locked at beat 2
        do_reset();
        set_reads();
        exp_gnt(1, 1'b0, 8'h41, 8'h00); exp_rd(1, ram_init(8'h41));
        exp_gnt(1, 1'b0, 8'h41, 8'h00); exp_rd(1, ram_init(8'h41));
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_gnt(0, 1'b0, 8'h40, 8'h00); exp_rd(0, ram_init(8'h40));
        exp_gnt(1, 1'b0, 8'h41, 8'h00); exp_rd(1, ram_init(8'h41));
        in_req = 4'b0010;
        cyc(2);
        in_req[0] = 1'b1;
        cyc(1);
        in_req[0] = 1'b0;
        cyc(1);
        in_req = 4'b0000;
`else
        exp_gnt(1, 1'b0, 8'h41, 8'h00); exp_rd(1, ram_init(8'h41));
        exp_gnt(1, 1'b0, 8'h41, 8'h00); exp_rd(1, ram_init(8'h41));
        exp_gnt(0, 1'b0, 8'h40, 8'h00); exp_rd(0, ram_init(8'h40));
        in_req = 4'b0010;
        cyc(2);
        in_req[0] = 1'b1;
        cyc(3);
        in_req = 4'b0000;
`endif
        cyc(4);

        check("gnt_queue_drained", 32'(gq.size()), 32'd0);
        check("rd_queue_drained", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running at %0t, need completion", $time);
        $fatal(1);
    end

endmodule
